// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns single-cycle event pulses into fixed-width high windows on
//   level_out, with a guaranteed low gap between consecutive windows.
//   Pulses that arrive while a window or gap is running are queued in a
//   saturating pending counter; a pulse lost to saturation sets overflow.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   pulse_in   event input, each high sample is one pulse
//   clear      synchronous flush (state, pending and overflow)
//   level_out  registered stretched output
//   busy       high whenever the FSM is not idle
//   pending    queued pulses not yet emitted
//   overflow   sticky: a pulse was dropped because pending was full
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic last_gap;
  logic pend_inc;
  logic pend_dec;

  // The final GAP edge either consumes a queued pulse or, with nothing
  // queued, accepts pulse_in directly without it touching pending.
  always_comb begin
    last_gap = (state == GAP) && (cnt == '0);
    pend_dec = last_gap && (pending != '0);
    pend_inc = pulse_in && (state != IDLE) && !(last_gap && (pending == '0));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      level_out <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      level_out <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      // Simultaneous increment and decrement cancel, even when saturated.
      if (pend_inc && !pend_dec) begin
        if (pending == PEND_MAX)
          overflow <= 1'b1;
        else
          pending <= pending + 1'b1;
      end else if (pend_dec && !pend_inc) begin
        pending <= pending - 1'b1;
      end

      case (state)
        IDLE: begin
          if (pulse_in) begin
            state     <= HIGH;
            level_out <= 1'b1;
            cnt       <= HIGH_LOAD;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            state     <= GAP;
            level_out <= 1'b0;
            cnt       <= GAP_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if ((pending != '0) || pulse_in) begin
              state     <= HIGH;
              level_out <= 1'b1;
              cnt       <= HIGH_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          level_out <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses into fixed-width, human/board-visible level windows, e.g. for LEDs, debug pins or slow consumers.
- Performs the reverse of the rising-edge single-pulse generator: it takes pulses in and produces levels out.
- Every accepted pulse yields exactly one high window on level_out, and windows are separated by a guaranteed low gap.
- Pulses arriving while a window or gap is in progress are queued in a saturating pending counter, not dropped.

Parameters:
- HIGH_CYCLES, default 4: length of each level_out high window in clk cycles. Legal values ≥1.
- GAP_CYCLES, default 2: minimum number of low cycles between consecutive windows. Legal values ≥1.
- PEND_W, default 3: width of the pending counter. Maximum queued pulses = 2^PEND_W-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pulse_in  in  1  event input. Each cycle sampled high counts as one pulse.
- clear  in  1  synchronous flush, highest priority after rst_n.
- level_out  out  1  registered stretched output.
- busy  out  1  high whenever state ≠ IDLE.
- pending  out  PEND_W  number of queued, not-yet-emitted pulses.
- overflow  out  1  sticky flag: a pulse was lost because pending was saturated.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, level_out=0, busy=0, pending=0, overflow=0, internal counter=0, immediately and without waiting for a clock edge.
- States: IDLE, HIGH, GAP. The down-counter is sized for max(HIGH_CYCLES, GAP_CYCLES).
- Timing convention: "pulse in cycle n" means pulse_in=1 at the rising edge that ends cycle n.
- IDLE:
  - pulse_in=1 in cycle n → HIGH. level_out=1 in cycles n+1 .. n+HIGH_CYCLES. No queueing.
- HIGH:
  - level_out=1.
  - After HIGH_CYCLES cycles → GAP, with level_out=0 from the next cycle.
- GAP:
  - level_out=0 for GAP_CYCLES cycles.
  - At the edge ending the last GAP cycle:
    - pending>0: pending-1 and → HIGH.
    - else pulse_in=1 on that edge: → HIGH directly, and the pulse is not queued.
    - else: → IDLE.
- Queueing (state HIGH or GAP, and not the direct-accept case above):
  - pulse_in=1: pending+1.
  - If pending is already 2^PEND_W-1: pending is held and overflow is set to 1.
- Simultaneous increment and decrement on the same edge:
  - pending is unchanged.
  - overflow is not set, even when pending is saturated.
- overflow is cleared only by rst_n or clear.
- clear=1 at an edge:
  - state=IDLE, level_out=0, pending=0, overflow=0.
  - A pulse_in on the same edge is discarded.
- Consecutive windows from queued pulses start every HIGH_CYCLES+GAP_CYCLES cycles.
- level_out never glitches. It is driven directly from a flop.
- A window in progress is never shortened or extended by new pulses; its only effect is the pending update.
- pulse_in held high for k cycles counts as k pulses.
- busy is combinational from the registered state only, with no path from pulse_in.
- Reset asserted mid-window: level_out drops asynchronously. After release the block starts in IDLE with no residual window.

Test Plan (defaults HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=3 unless noted):
1. Single pulse in cycle 10 → level_out=1 in cycles 11–14 and 0 from 15. busy=1 in cycles 11–16, 0 from 17. pending stays 0.
2. Pulses in cycles 10, 11, 12:
   - Windows in cycles 11–14, 17–20, 23–26.
   - pending=2 after cycle 12, 1 after cycle 16, 0 after cycle 22. overflow=0.
3. HIGH_CYCLES=16, pulses in cycles 10–18:
   - Cycle 10 pulse is accepted; cycles 11–17 fill pending to 7.
   - Cycle 18 pulse sets overflow=1 with pending held at 7.
   - Exactly 8 windows are emitted; overflow stays 1 afterwards.
4. Pulse in cycle 10, then second pulse in cycle 16 (last GAP cycle, pending=0) → second window in cycles 17–20. pending never becomes nonzero.
5. rst_n driven low mid-cycle 12 during a window, with pending=2 → level_out, pending and overflow are 0 before the next clk edge. After release with no pulses, level_out stays 0.
6. clear=1 and pulse_in=1 together in cycle 13 during a window, with pending=3 → from cycle 14: level_out=0, busy=0, pending=0. No further windows.
